// File: rtl/pre_spike_encoder.sv
// Rate-codes pixel intensities into per-bundle pre-synaptic spikes using per-lane LFSRs,
// and maintains a decaying, saturating 16-bit trace per input in an internal RAM.
module pre_spike_encoder #(
    parameter int unsigned SEED      = 1000,
    parameter int unsigned LANES     = 24,
    parameter int unsigned N_PIX     = 784,
    parameter int unsigned N_BUNDLE  = 33,
    parameter int unsigned AW        = 6,
    parameter int unsigned TAU_SHIFT = 4,
    parameter logic [15:0] X_INC     = 16'd4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_init,
    input  logic                  i_ready,
    output logic [AW-1:0]         o_pix_addr,
    output logic                  o_pix_ce,
    input  logic [LANES*8-1:0]    i_pix_q,
    output logic [LANES-1:0]      o_spike_bundle,
    output logic [LANES*16-1:0]   o_x_trace,
    output logic [AW-1:0]         o_bundle_idx,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RD   = 3'd2,
        S_CALC = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_BUNDLE - 1);

    state_t                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic                  clr_done_q, clr_done_d;
    logic                  valid_q;
    logic [LANES-1:0]      spike_q;
    logic [LANES*16-1:0]   trace_q;
    logic [AW-1:0]         bidx_q;
    logic [15:0]           lfsr_q   [LANES];
    logic [15:0]           lfsr_nxt [LANES];
    logic [LANES*16-1:0]   trace_ram [N_BUNDLE];
    logic [LANES*16-1:0]   trace_rd_q;
    logic [LANES-1:0]      spike_c;
    logic [LANES*16-1:0]   trace_c;
    logic [16:0]           sum_c [LANES];

    function automatic logic [15:0] lane_seed(input int unsigned l);
        logic [15:0] s;
        s = 16'((SEED + 257 * l) & 32'hFFFF);
        return (s == 16'd0) ? 16'hACE1 : s;
    endfunction

    // Handshake: a bundle is transferred on any cycle where o_valid && i_ready; while
    // o_valid is high and i_ready is low, bundle, traces and index hold steady.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clr_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_init) begin
                    state_d = S_CLR;
                    idx_d   = '0;
                end else if (i_start) begin
                    state_d = S_RD;
                    idx_d   = '0;
                end
            end
            S_CLR: begin
                if (idx_q == LAST_IDX) begin
                    state_d    = S_IDLE;
                    idx_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_RD:   state_d = S_CALC;
            S_CALC: state_d = S_OUT;
            S_OUT: begin
                if (valid_q && i_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decay never underflows since x >> TAU_SHIFT <= x; bit 16 flags saturation.
    always_comb begin
        spike_c = '0;
        trace_c = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            spike_c[l] = (lfsr_q[l][7:0] < i_pix_q[l*8 +: 8]) &&
                         ((32'(idx_q) * LANES + 32'(l)) < N_PIX);
            sum_c[l]   = {1'b0, trace_rd_q[l*16 +: 16]}
                       - {1'b0, (trace_rd_q[l*16 +: 16] >> TAU_SHIFT)}
                       + (spike_c[l] ? {1'b0, X_INC} : 17'd0);
            trace_c[l*16 +: 16] = sum_c[l][16] ? 16'hFFFF : sum_c[l][15:0];
            lfsr_nxt[l] = {lfsr_q[l][14:0],
                           lfsr_q[l][15] ^ lfsr_q[l][13] ^ lfsr_q[l][12] ^ lfsr_q[l][10]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            clr_done_q <= 1'b0;
            valid_q    <= 1'b0;
            spike_q    <= '0;
            trace_q    <= '0;
            bidx_q     <= '0;
            for (int l = 0; l < int'(LANES); l++) begin
                lfsr_q[l] <= lane_seed(l);
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_done_q <= clr_done_d;
            if (state_q == S_CALC) begin
                valid_q <= 1'b1;
                spike_q <= spike_c;
                trace_q <= trace_c;
                bidx_q  <= idx_q;
                lfsr_q  <= lfsr_nxt;
            end else if (state_q == S_OUT && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Trace RAM deliberately has no reset; only the CLR walk zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_CLR) begin
                trace_ram[idx_q] <= '0;
            end else if (state_q == S_CALC) begin
                trace_ram[idx_q] <= trace_c;
            end
        end
        if (state_q == S_RD) begin
            trace_rd_q <= trace_ram[idx_q];
        end
    end

    assign o_pix_addr     = idx_q;
    assign o_pix_ce       = (state_q == S_RD);
    assign o_spike_bundle = spike_q;
    assign o_x_trace      = trace_q;
    assign o_bundle_idx   = bidx_q;
    assign o_valid        = valid_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_done         = (state_q == S_DONE) || clr_done_q;
    assign o_dbg_state    = state_q;

endmodule
